// File: rtl/vx_lsu_rsp_gather.sv
// LSU response gather: per-slot collection of lane responses until a request completes, then commit.
// Define LSU_GATHER_INORDER_EN for FIFO allocation/commit; default is lowest-index (out-of-order) mode.
module vx_lsu_rsp_gather #(
  parameter  int NUM_LANES  = 4,
  parameter  int QUEUE_SIZE = 8,
  parameter  int META_W     = 40,
  localparam int TAG_W      = $clog2(QUEUE_SIZE),
  localparam int CNT_W      = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NUM_LANES-1:0]      req_tmask,
  input  logic [META_W-1:0]         req_meta,
  output logic [TAG_W-1:0]          req_tag,
  input  logic [NUM_LANES-1:0]      rsp_valid,
  input  logic [TAG_W-1:0]          rsp_tag,
  input  logic [NUM_LANES*32-1:0]   rsp_data,
  output logic                      rsp_ready,
  output logic                      cmt_valid,
  input  logic                      cmt_ready,
  output logic [NUM_LANES-1:0]      cmt_tmask,
  output logic [META_W-1:0]         cmt_meta,
  output logic [NUM_LANES*32-1:0]   cmt_data,
  output logic [CNT_W-1:0]          pending_cnt
);

  logic [QUEUE_SIZE-1:0]     busy_q;
  logic [QUEUE_SIZE-1:0]     done_q;
  logic [NUM_LANES-1:0]      rem_q   [QUEUE_SIZE];
  logic [NUM_LANES-1:0]      tmask_q [QUEUE_SIZE];
  logic [META_W-1:0]         meta_q  [QUEUE_SIZE];
  logic [NUM_LANES*32-1:0]   data_q  [QUEUE_SIZE];
  logic [CNT_W-1:0]          cnt_q;

  logic [TAG_W-1:0]          alloc_idx;
  logic [TAG_W-1:0]          cmt_idx;
  logic                      alloc_fire;
  logic                      cmt_fire;
  logic [NUM_LANES-1:0]      rsp_wmask;

  assign rsp_ready   = 1'b1;
  assign req_ready   = ~&busy_q;
  assign req_tag     = alloc_idx;
  assign alloc_fire  = req_valid && req_ready;
  assign cmt_fire    = cmt_valid && cmt_ready;
  assign pending_cnt = cnt_q;

  // Only lanes still outstanding on a live slot accept data; duplicates fall away here.
  assign rsp_wmask = busy_q[rsp_tag] ? (rsp_valid & rem_q[rsp_tag]) : '0;

  assign cmt_tmask = tmask_q[cmt_idx];
  assign cmt_meta  = meta_q[cmt_idx];
  assign cmt_data  = data_q[cmt_idx];

`ifdef LSU_GATHER_INORDER_EN
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;

  assign alloc_idx = tail_q;
  assign cmt_idx   = head_q;
  assign cmt_valid = done_q[head_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + 1'b1;
      if (cmt_fire)   head_q <= head_q + 1'b1;
    end
  end
`else
  logic             hold_q;
  logic [TAG_W-1:0] hold_idx_q;
  logic [TAG_W-1:0] low_free;
  logic [TAG_W-1:0] low_done;

  always_comb begin
    low_free = '0;
    low_done = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) low_free = TAG_W'(i);
      if (done_q[i])  low_done = TAG_W'(i);
    end
  end

  // A stalled commit keeps its slot even if a lower index completes meanwhile.
  assign alloc_idx = low_free;
  assign cmt_idx   = hold_q ? hold_idx_q : low_done;
  assign cmt_valid = hold_q | (|done_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= cmt_valid && !cmt_ready;
      hold_idx_q <= cmt_idx;
    end
  end
`endif

  // Slot control; later assignments (commit, alloc) take priority within a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      done_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) rem_q[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (rsp_tag == TAG_W'(i) && |rsp_wmask) begin
          rem_q[i] <= rem_q[i] & ~rsp_wmask;
          if ((rem_q[i] & ~rsp_wmask) == '0) done_q[i] <= 1'b1;
        end
        if (cmt_fire && cmt_idx == TAG_W'(i)) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b0;
        end
        if (alloc_fire && alloc_idx == TAG_W'(i)) begin
          busy_q[i] <= 1'b1;
          rem_q[i]  <= req_tmask;
          done_q[i] <= (req_tmask == '0);
        end
      end
      case ({alloc_fire, cmt_fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      tmask_q[alloc_idx] <= req_tmask;
      meta_q[alloc_idx]  <= req_meta;
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (rsp_wmask[l]) data_q[rsp_tag][l*32 +: 32] <= rsp_data[l*32 +: 32];
    end
  end

  rsp_to_live_slot: assert property (@(posedge clk) disable iff (!reset)
    (|rsp_valid) |-> busy_q[rsp_tag]);

endmodule

// File: tb/tb_vx_lsu_rsp_gather.sv
// Scoreboard bench for vx_lsu_rsp_gather: expected commits are queued at stimulus time and checked on commit fire.
module tb_vx_lsu_rsp_gather;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid, req_ready;
  logic [3:0]   req_tmask;
  logic [39:0]  req_meta;
  logic [2:0]   req_tag;
  logic [3:0]   rsp_valid;
  logic [2:0]   rsp_tag;
  logic [127:0] rsp_data;
  logic         rsp_ready;
  logic         cmt_valid, cmt_ready;
  logic [3:0]   cmt_tmask;
  logic [39:0]  cmt_meta;
  logic [127:0] cmt_data;
  logic [3:0]   pending_cnt;

  int checks = 0;
  int failures = 0;
  int commits = 0;

  typedef struct {
    logic [3:0]   tmask;
    logic [39:0]  meta;
    logic [127:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [127:0] lane_mask;

  vx_lsu_rsp_gather dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tmask(req_tmask),
    .req_meta(req_meta), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_tmask(cmt_tmask),
    .cmt_meta(cmt_meta), .cmt_data(cmt_data), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  // Commit monitor: every commit fire must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && cmt_valid && cmt_ready) begin
      commits++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_commit meta=%0h tmask=%0h required=none", cmt_meta, cmt_tmask);
      end else begin
        mon_e = sb.pop_front();
        for (int l = 0; l < 4; l++) lane_mask[l*32 +: 32] = {32{mon_e.tmask[l]}};
        if (cmt_tmask !== mon_e.tmask || cmt_meta !== mon_e.meta ||
            (cmt_data & lane_mask) !== (mon_e.data & lane_mask)) begin
          failures++;
          $display("[TB] FAIL commit got tmask=%0h meta=%0h data=%0h required tmask=%0h meta=%0h data=%0h",
                   cmt_tmask, cmt_meta, cmt_data & lane_mask, mon_e.tmask, mon_e.meta,
                   mon_e.data & lane_mask);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] mk_data(input logic [7:0] b);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = {24'h0, b} + 32'(l);
    return r;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = 1'b0; req_tmask = '0; req_meta = '0;
    rsp_valid = '0; rsp_tag = '0; rsp_data = '0;
    cmt_ready = 1'b0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1'b0;
    sb.delete();
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  task automatic alloc(input logic [3:0] tm, input logic [39:0] mt, output logic [2:0] tag);
    req_valid = 1'b1; req_tmask = tm; req_meta = mt;
    @(negedge clk);
    tag = req_tag;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [2:0] tag, input logic [3:0] lanes, input logic [127:0] d);
    rsp_valid = lanes; rsp_tag = tag; rsp_data = d;
    next_cycle();
    rsp_valid = '0;
  endtask

  task automatic drain(input int budget);
    cmt_ready = 1'b1;
    for (int k = 0; k < budget && sb.size() > 0; k++) next_cycle();
    cmt_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || cmt_valid !== 1'b0 || pending_cnt !== 4'd0 || rsp_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state got rdy=%b cv=%b cnt=%0d rr=%b required 1 0 0 1",
               req_ready, cmt_valid, pending_cnt, rsp_ready);
    end
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_gather;
    logic [2:0] t;
    logic [127:0] d;
    apply_reset();
    d = mk_data(8'hA0);
    sb.push_back('{4'hF, 40'hA23, d});
    alloc(4'hF, 40'hA23, t);
    checks++;
    if (t !== 3'd0) begin failures++; $display("[TB] FAIL gather_tag got=%0d required=0", t); end
    for (int c = 1; c <= 9; c++) begin
      rsp_valid = (c == 5) ? 4'b0011 : (c == 8) ? 4'b1100 : 4'b0000;
      rsp_tag = t; rsp_data = d;
      cmt_ready = (c == 9);
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (pending_cnt !== 4'd1) begin failures++; $display("[TB] FAIL gather_cnt got=%0d required=1", pending_cnt); end
      end
      if (c == 8) begin
        checks++;
        if (cmt_valid !== 1'b0) begin failures++; $display("[TB] FAIL gather_early got=%b required=0", cmt_valid); end
      end
      if (c == 9) begin
        checks++;
        if (cmt_valid !== 1'b1 || cmt_data !== d || cmt_tmask !== 4'hF) begin
          failures++;
          $display("[TB] FAIL gather_c9 got v=%b d=%0h m=%0h required 1 %0h f", cmt_valid, cmt_data, cmt_tmask, d);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (pending_cnt !== 4'd0 || cmt_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL gather_after got cnt=%0d v=%b left=%0d required 0 0 0", pending_cnt, cmt_valid, sb.size());
    end
    next_cycle();
  endtask

  task automatic test_full;
    logic [2:0] t;
    logic [127:0] d2;
    apply_reset();
    d2 = mk_data(8'h50);
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{4'h0, 40'(256 + i), 128'h0});
      alloc(4'h0, 40'(256 + i), t);
      checks++;
      if (t !== 3'(i)) begin failures++; $display("[TB] FAIL full_tag got=%0d required=%0d", t, i); end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || pending_cnt !== 4'd8 || cmt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_state got rdy=%b cnt=%0d v=%b required 0 8 1", req_ready, pending_cnt, cmt_valid);
    end
    next_cycle();
    cmt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_release_same got=%b required=0", req_ready); end
    next_cycle();
    req_valid = 1'b1; req_tmask = 4'b0001; req_meta = 40'h1FF;
    sb.push_back('{4'b0001, 40'h1FF, d2});
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || req_tag !== 3'd0 || pending_cnt !== 4'd7) begin
      failures++;
      $display("[TB] FAIL full_realloc got rdy=%b tag=%0d cnt=%0d required 1 0 7", req_ready, req_tag, pending_cnt);
    end
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending_cnt !== 4'd7) begin failures++; $display("[TB] FAIL full_both_fire got=%0d required=7", pending_cnt); end
    next_cycle();
    for (int k = 0; k < 20 && sb.size() > 1; k++) next_cycle();
    checks++;
    if (sb.size() != 1) begin failures++; $display("[TB] FAIL full_drain got=%0d required=1", sb.size()); end
    respond(3'd0, 4'b0001, d2);
    drain(10);
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || pending_cnt !== 4'd0) begin
      failures++;
      $display("[TB] FAIL full_end got left=%0d cnt=%0d required 0 0", sb.size(), pending_cnt);
    end
    next_cycle();
  endtask

  task automatic test_order;
    logic [2:0] t0, t1;
    logic [127:0] da, db;
    logic [39:0] exp_meta;
    apply_reset();
    da = mk_data(8'h10);
    db = mk_data(8'h20);
    alloc(4'b0011, 40'hAAA, t0);
    alloc(4'b0011, 40'hBBB, t1);
    checks++;
    if (t0 !== 3'd0 || t1 !== 3'd1) begin failures++; $display("[TB] FAIL order_tags got=%0d,%0d required 0,1", t0, t1); end
`ifdef LSU_GATHER_INORDER_EN
    sb.push_back('{4'b0011, 40'hAAA, da});
    sb.push_back('{4'b0011, 40'hBBB, db});
    exp_meta = 40'hAAA;
`else
    sb.push_back('{4'b0011, 40'hBBB, db});
    sb.push_back('{4'b0011, 40'hAAA, da});
    exp_meta = 40'hBBB;
`endif
    respond(t1, 4'b0011, db);
    next_cycle();
    @(negedge clk);
    checks++;
`ifdef LSU_GATHER_INORDER_EN
    if (cmt_valid !== 1'b0) begin failures++; $display("[TB] FAIL order_hold got=%b required=0", cmt_valid); end
`else
    if (cmt_valid !== 1'b1 || cmt_meta !== 40'hBBB) begin
      failures++;
      $display("[TB] FAIL order_first got v=%b meta=%0h required 1 bbb", cmt_valid, cmt_meta);
    end
`endif
    next_cycle();
    respond(t0, 4'b0011, da);
    @(negedge clk);
    checks++;
    if (cmt_valid !== 1'b1 || cmt_meta !== exp_meta) begin
      failures++;
      $display("[TB] FAIL order_present got v=%b meta=%0h required 1 %0h", cmt_valid, cmt_meta, exp_meta);
    end
    next_cycle();
    drain(10);
    checks++;
    if (sb.size() != 0) begin failures++; $display("[TB] FAIL order_drain got=%0d required=0", sb.size()); end
  endtask

  task automatic test_zero_mask;
    apply_reset();
    req_valid = 1'b1; req_tmask = 4'h0; req_meta = 40'hCAFE;
    sb.push_back('{4'h0, 40'hCAFE, 128'h0});
    @(negedge clk);
    checks++;
    if (cmt_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_early got=%b required=0", cmt_valid); end
    next_cycle();
    req_valid = 1'b0;
    cmt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmt_valid !== 1'b1 || cmt_tmask !== 4'h0 || cmt_meta !== 40'hCAFE) begin
      failures++;
      $display("[TB] FAIL zero_commit got v=%b m=%0h meta=%0h required 1 0 cafe", cmt_valid, cmt_tmask, cmt_meta);
    end
    next_cycle();
    cmt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (pending_cnt !== 4'd0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL zero_after got cnt=%0d left=%0d required 0 0", pending_cnt, sb.size());
    end
    next_cycle();
  endtask

  task automatic test_stall;
    logic [2:0] t;
    logic [127:0] d, alt;
    apply_reset();
    d = mk_data(8'hC0);
    alt = mk_data(8'hE0);
    alloc(4'hF, 40'hD00D, t);
    sb.push_back('{4'hF, 40'hD00D, d});
    respond(t, 4'b0001, d);
    respond(t, 4'b0001, alt);
    respond(t, 4'b1110, d);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin rsp_valid = 4'hF; rsp_tag = t; rsp_data = alt; end
      else rsp_valid = '0;
      @(negedge clk);
      checks++;
      if (cmt_valid !== 1'b1 || cmt_data !== d || cmt_meta !== 40'hD00D || cmt_tmask !== 4'hF) begin
        failures++;
        $display("[TB] FAIL stall_stable k=%0d got v=%b d=%0h meta=%0h required 1 %0h d00d", k, cmt_valid, cmt_data, cmt_meta, d);
      end
      next_cycle();
    end
    rsp_valid = '0;
    drain(5);
    checks++;
    if (sb.size() != 0) begin failures++; $display("[TB] FAIL stall_drain got=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_midway;
    logic [2:0] t;
    int c0;
    apply_reset();
    alloc(4'hF, 40'h1, t);
    alloc(4'h3, 40'h2, t);
    alloc(4'h0, 40'h3, t);
    @(negedge clk);
    checks++;
    if (pending_cnt !== 4'd3 || cmt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_pre got cnt=%0d v=%b required 3 1", pending_cnt, cmt_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pending_cnt !== 4'd0 || cmt_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_now got cnt=%0d v=%b rdy=%b required 0 0 1", pending_cnt, cmt_valid, req_ready);
    end
    next_cycle();
    reset = 1'b1;
    c0 = commits;
    cmt_ready = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    checks++;
    if (commits != c0 || cmt_valid !== 1'b0 || pending_cnt !== 4'd0) begin
      failures++;
      $display("[TB] FAIL midreset_after got commits=%0d v=%b cnt=%0d required %0d 0 0", commits, cmt_valid, pending_cnt, c0);
    end
    next_cycle();
    cmt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gather();
    test_full();
    test_order();
    test_zero_mask();
    test_stall();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_lsu_rsp_gather.md
VX_LSU_RSP_GATHER -- requirements
Module: VX_lsu_rsp_gather

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_LANES SHALL default to 4 and set the lane count (1..32).
REQ-003 Parameter QUEUE_SIZE SHALL default to 8 and set the pending-slot count (power of 2, >=2).
REQ-004 Parameter META_W SHALL default to 40 and set the opaque per-request metadata width (wid/PC/rd/wb/fmt).
REQ-005 Derived TAG_W SHALL equal clog2(QUEUE_SIZE); CNT_W SHALL equal clog2(QUEUE_SIZE+1).
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-low reset
- req_valid  in  1  allocate request
- req_ready  out  1  free slot available
- req_tmask  in  NUM_LANES  lanes expecting a response
- req_meta  in  META_W  metadata stored with the slot
- req_tag  out  TAG_W  slot index granted; valid when req_valid&&req_ready
- rsp_valid  in  NUM_LANES  per-lane response valid
- rsp_tag  in  TAG_W  slot the response belongs to
- rsp_data  in  NUM_LANES*32  per-lane response data
- rsp_ready  out  1  response accepted
- cmt_valid  out  1  gathered request ready to commit
- cmt_ready  in  1  commit consumer ready
- cmt_tmask  out  NUM_LANES  original tmask of committed slot
- cmt_meta  out  META_W  metadata of committed slot
- cmt_data  out  NUM_LANES*32  gathered lane data
- pending_cnt  out  CNT_W  slots currently allocated

Function
REQ-007 Each slot SHALL hold: busy, done, tmask, remaining-mask, meta and NUM_LANES*32 data.
REQ-008 req_ready SHALL be 1 iff at least one slot is not busy; a slot released this cycle is not allocatable until the next cycle.
REQ-009 On alloc fire, the slot at req_tag SHALL be set busy, remaining-mask=req_tmask, done=(req_tmask==0).
REQ-010 rsp_ready SHALL be tied to 1; responses are never back-pressured.
REQ-011 On rsp fire, lanes with rsp_valid[i]&&remaining[i] SHALL write data lane i and clear remaining[i]; other lanes are ignored.
REQ-012 A response to a non-busy slot SHALL be ignored and SHALL fire a simulation assertion.
REQ-013 When remaining-mask becomes 0 at cycle N, done SHALL be set at N+1 and cmt_valid SHALL be asserted no earlier than N+1.
REQ-014 cmt_* SHALL present the selected done slot; outputs SHALL remain stable while cmt_valid&&!cmt_ready.
REQ-015 On commit fire, the slot SHALL be cleared (busy=0, done=0) at the next edge.
REQ-016 Simultaneous alloc, response and commit in one cycle SHALL all take effect; a response completing the slot being committed is impossible (done slot has remaining=0).
REQ-017 pending_cnt SHALL be +1 on alloc fire, -1 on commit fire, unchanged when both fire.

Reset
REQ-018 While reset is low: all slots not busy/done, req_ready=1, cmt_valid=0, pending_cnt=0, pointers=0; rsp_ready=1.
REQ-019 Assertion of reset mid-operation SHALL discard all pending slots without emitting commits.

Configuration
REQ-020 Macro LSU_GATHER_INORDER_EN SHALL select the ordering mode.
REQ-021 With LSU_GATHER_INORDER_EN defined: allocation SHALL use a tail pointer and commit SHALL present only the head slot (oldest), each pointer wrapping modulo QUEUE_SIZE; a done non-head slot waits.
REQ-022 Without LSU_GATHER_INORDER_EN: allocation SHALL grant the lowest-index free slot and commit SHALL present the lowest-index done slot.

Verification
REQ-023 Alloc tmask=4'b1111, responses lanes 0-1 at cycle 5, lanes 2-3 at cycle 8 with data 0xA0..0xA3 -> cmt_valid at cycle 9, cmt_data={A3,A2,A1,A0}, cmt_tmask=1111.
REQ-024 Allocate 8 slots with QUEUE_SIZE=8 -> req_ready=0, pending_cnt=8; commit one -> req_ready=1 the cycle after commit fire.
REQ-025 Out-of-order mode: alloc tags 0,1; complete tag 1 first -> tag 1 commits first; in-order build -> tag 1 held until tag 0 commits.
REQ-026 Alloc tmask=0 -> cmt_valid the next cycle with cmt_tmask=0, meta echoed.
REQ-027 cmt_ready=0 for 5 cycles with cmt_valid=1 -> cmt_* stable; duplicate response to lane already cleared -> data unchanged.
REQ-028 Reset low with 3 pending slots -> pending_cnt=0, cmt_valid=0 immediately, no commit after release.
